iob2axil: RTL and testbench
===========================

# iob2axil

Bridge converting IOb slave-side requests into AXI4-Lite master transactions, one outstanding transfer at a time. It sits between an IOb initiator, such as a CPU or DMA, and an AXI4-Lite peripheral or interconnect. A 5-state FSM sequences the address/data, response and read-data phases, and registers every AXI-Lite output.

## Interface
- ADDR_W, 21, IOb address width
- DATA_W, 32, IOb data width; must be a multiple of 8
- AXIL_ADDR_W, ADDR_W, AXI-Lite address width; iob_addr_i is zero-extended or truncated to fit
- AXIL_DATA_W, DATA_W, AXI-Lite data width; must equal DATA_W

Ports (clock and reset first):
- clk_i  in  1  clock; all state changes on the rising edge
- arst_n_i  in  1  asynchronous active-low reset
- iob_avalid_i  in  1  request valid
- iob_addr_i  in  ADDR_W  byte address
- iob_wdata_i  in  DATA_W  write data
- iob_wstrb_i  in  DATA_W/8  byte enables; non-zero means write, zero means read
- iob_rvalid_o  out  1  read data valid, one-cycle pulse
- iob_rdata_o  out  DATA_W  read data
- iob_ready_o  out  1  request accepted when high together with avalid
- axil_awaddr_o, axil_awprot_o(3), axil_awvalid_o  out; axil_awready_i  in
- axil_wdata_o, axil_wstrb_o, axil_wvalid_o  out; axil_wready_i  in
- axil_bresp_i(2), axil_bvalid_i  in; axil_bready_o  out
- axil_araddr_o, axil_arprot_o(3), axil_arvalid_o  out; axil_arready_i  in
- axil_rdata_i, axil_rresp_i(2), axil_rvalid_i  in; axil_rready_o  out

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA.
- iob_ready_o = (state==IDLE).
- IDLE: on avalid, register addr, wdata and wstrb.
  - wstrb≠0 → WR_REQ, with awvalid and wvalid set.
  - wstrb=0 → RD_REQ, with arvalid set.
- WR_REQ: awvalid and wvalid are cleared independently when their own ready is high.
  - Once both handshakes have completed (same cycle or different cycles), go to WR_RESP with bready=1.
- WR_RESP: on bvalid, clear bready and go to IDLE. bresp is ignored unless the configuration feature is compiled in.
- RD_REQ: on arready, clear arvalid, set rready and go to RD_DATA.
- RD_DATA: on rvalid, capture rdata into iob_rdata_o, pulse iob_rvalid_o for 1 cycle, clear rready and go to IDLE.
- awprot and arprot are fixed at 3'b000.
- The AXI valid signals are held stable until their handshake completes, and the address, data and strobe are held constant while valid is high.
- avalid while ready is low is not a request; the initiator must hold it.

## Timing
- On reset, every output is 0 and the state is IDLE. iob_ready_o rises in the first cycle after deassertion.
- Reset mid-transaction returns the block to IDLE immediately and drops all valid and ready outputs. This is AXI-legal only if the slave is reset too.
- Write with zero-wait slave: accept on edge 0; aw/w valid in cycle 1; bready in cycle 2; iob_ready_o high again in cycle 3.
- Read with zero-wait slave: accept on edge 0; arvalid in cycle 1; rready in cycle 2; iob_rvalid_o and iob_ready_o both high in cycle 3.
- iob_rdata_o keeps its value until the next read completes.
- A new request can be accepted in the same cycle that iob_rvalid_o pulses.

## Configuration
- IOB2AXIL_RESP_ERR_EN defined: adds the ports err_o (out, 1) and err_clr_i (in, 1).
  - err_o is a sticky flag, set on a B or R handshake with resp≠2'b00 and reset to 0.
  - err_clr_i clears it; if clear and set occur in the same cycle, set wins.
- Not defined: those ports do not exist and the response codes are ignored.

## Test plan
- Write 0x0000_0010 ← 0xDEADBEEF, wstrb 4'hF, all AXI readies tied to 1 → awaddr=0x10, wdata=0xDEADBEEF, wstrb=F in cycle 1; iob_ready_o low for cycles 1-2, high in cycle 3.
- Write with awready delayed by 3 cycles and wready immediate → wvalid drops after 1 cycle, awvalid is held for 4 cycles, bready is asserted only after both handshakes.
- Read 0x24, arready=1, rvalid delayed by 2 cycles with rdata=0x12345678 → iob_rvalid_o is a 1-cycle pulse, iob_rdata_o=0x12345678 and stays stable afterwards.
- Back-to-back: a write then a read, with avalid held high → the second request is accepted only when iob_ready_o returns high, and no AXI valid overlaps between the two transfers.
- Reset asserted while in RD_DATA → all outputs go to 0 asynchronously, then the block returns to IDLE; a read issued afterwards completes normally.
- With IOB2AXIL_RESP_ERR_EN: bresp=2'b10 → err_o=1 and stays set; err_clr_i pulse → err_o=0 on the next cycle.

Source files
------------

// File: rtl/iob2axil.sv
// iob2axil: IOb slave to AXI4-Lite master bridge, one transfer in flight; define IOB2AXIL_RESP_ERR_EN to add a sticky response error flag (err_o/err_clr_i)
module iob2axil #(
  parameter int ADDR_W      = 21,
  parameter int DATA_W      = 32,
  parameter int AXIL_ADDR_W = ADDR_W,
  parameter int AXIL_DATA_W = DATA_W
) (
  input  logic                     clk_i,
  input  logic                     arst_n_i,
  input  logic                     iob_avalid_i,
  input  logic [ADDR_W-1:0]        iob_addr_i,
  input  logic [DATA_W-1:0]        iob_wdata_i,
  input  logic [DATA_W/8-1:0]      iob_wstrb_i,
  output logic                     iob_rvalid_o,
  output logic [DATA_W-1:0]        iob_rdata_o,
  output logic                     iob_ready_o,
  output logic [AXIL_ADDR_W-1:0]   axil_awaddr_o,
  output logic [2:0]               axil_awprot_o,
  output logic                     axil_awvalid_o,
  input  logic                     axil_awready_i,
  output logic [AXIL_DATA_W-1:0]   axil_wdata_o,
  output logic [AXIL_DATA_W/8-1:0] axil_wstrb_o,
  output logic                     axil_wvalid_o,
  input  logic                     axil_wready_i,
  input  logic [1:0]               axil_bresp_i,
  input  logic                     axil_bvalid_i,
  output logic                     axil_bready_o,
  output logic [AXIL_ADDR_W-1:0]   axil_araddr_o,
  output logic [2:0]               axil_arprot_o,
  output logic                     axil_arvalid_o,
  input  logic                     axil_arready_i,
  input  logic [AXIL_DATA_W-1:0]   axil_rdata_i,
  input  logic [1:0]               axil_rresp_i,
  input  logic                     axil_rvalid_i,
  output logic                     axil_rready_o
`ifdef IOB2AXIL_RESP_ERR_EN
  ,
  output logic                     err_o,
  input  logic                     err_clr_i
`endif
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA} state_t;
  state_t state;
  logic [AXIL_ADDR_W-1:0] addr;
  logic wr_done;
  assign axil_awaddr_o = addr;
  assign axil_araddr_o = addr;
  assign axil_awprot_o = 3'b000;
  assign axil_arprot_o = 3'b000;
  assign wr_done = (!axil_awvalid_o || axil_awready_i) && (!axil_wvalid_o || axil_wready_i);
  // Transfer sequencer; ready is a register so it stays low through reset and rises one edge later
  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) begin
      state          <= IDLE;
      addr           <= '0;
      axil_wdata_o   <= '0;
      axil_wstrb_o   <= '0;
      axil_awvalid_o <= 1'b0;
      axil_wvalid_o  <= 1'b0;
      axil_bready_o  <= 1'b0;
      axil_arvalid_o <= 1'b0;
      axil_rready_o  <= 1'b0;
      iob_rvalid_o   <= 1'b0;
      iob_rdata_o    <= '0;
      iob_ready_o    <= 1'b0;
    end else begin
      iob_rvalid_o <= 1'b0;
      case (state)
        IDLE:
          if (iob_avalid_i && iob_ready_o) begin
            addr         <= AXIL_ADDR_W'(iob_addr_i);
            axil_wdata_o <= iob_wdata_i;
            axil_wstrb_o <= iob_wstrb_i;
            iob_ready_o  <= 1'b0;
            if (|iob_wstrb_i) begin
              state          <= WR_REQ;
              axil_awvalid_o <= 1'b1;
              axil_wvalid_o  <= 1'b1;
            end else begin
              state          <= RD_REQ;
              axil_arvalid_o <= 1'b1;
            end
          end else iob_ready_o <= 1'b1;
        WR_REQ: begin
          if (axil_awready_i) axil_awvalid_o <= 1'b0;
          if (axil_wready_i) axil_wvalid_o <= 1'b0;
          if (wr_done) begin
            state         <= WR_RESP;
            axil_bready_o <= 1'b1;
          end
        end
        WR_RESP:
          if (axil_bvalid_i) begin
            state         <= IDLE;
            axil_bready_o <= 1'b0;
            iob_ready_o   <= 1'b1;
          end
        RD_REQ:
          if (axil_arready_i) begin
            state          <= RD_DATA;
            axil_arvalid_o <= 1'b0;
            axil_rready_o  <= 1'b1;
          end
        RD_DATA:
          if (axil_rvalid_i) begin
            state         <= IDLE;
            iob_rdata_o   <= axil_rdata_i;
            iob_rvalid_o  <= 1'b1;
            axil_rready_o <= 1'b0;
            iob_ready_o   <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
`ifdef IOB2AXIL_RESP_ERR_EN
  // Sticky error: a non-OKAY B or R handshake sets it and beats a same-cycle clear
  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) err_o <= 1'b0;
    else if ((axil_bvalid_i && axil_bready_o && |axil_bresp_i) || (axil_rvalid_i && axil_rready_o && |axil_rresp_i)) err_o <= 1'b1;
    else if (err_clr_i) err_o <= 1'b0;
`else
  logic unused;
  assign unused = ^{axil_bresp_i, axil_rresp_i};
`endif
endmodule

// File: tb/tb_iob2axil.sv
// tb_iob2axil: table-driven bench for iob2axil with an AXI-Lite slave model and scoreboard queues
`timescale 1ns/1ps
module tb_iob2axil;
  logic clk = 0, arst_n = 0;
  logic avalid = 0;
  logic [20:0] addr = 0;
  logic [31:0] wdata = 0;
  logic [3:0] wstrb = 0;
  logic rvalid_o, ready_o;
  logic [31:0] rdata_o;
  logic [20:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic awvalid, wvalid, bready, arvalid, rready;
  logic awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
  logic [31:0] wdata_ax, rdata = 0;
  logic [3:0] wstrb_ax;
  logic [1:0] bresp = 0, rresp = 0;
`ifdef IOB2AXIL_RESP_ERR_EN
  logic err, err_clr = 0;
`endif
  int compared = 0, mismatched = 0;
  int aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0, b_dly = 0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0, b_cnt = 0;
  int aw_cycles = 0, w_cycles = 0;
  logic [31:0] r_val = 0;
  logic [1:0] resp_val = 0;
  logic rv_prev = 0;
  typedef struct packed {logic [20:0] a; logic [31:0] d; logic [3:0] s;} wexp_t;
  wexp_t wq[$];
  logic [20:0] aq[$];
  logic [31:0] rq[$];
  typedef struct {logic we; logic [20:0] a; logic [31:0] d; logic [3:0] s; int aw, w, ar, r, b; logic [31:0] rd;} vec_t;
  vec_t tbl[6];

  iob2axil dut (
    .clk_i(clk), .arst_n_i(arst_n),
    .iob_avalid_i(avalid), .iob_addr_i(addr), .iob_wdata_i(wdata), .iob_wstrb_i(wstrb),
    .iob_rvalid_o(rvalid_o), .iob_rdata_o(rdata_o), .iob_ready_o(ready_o),
    .axil_awaddr_o(awaddr), .axil_awprot_o(awprot), .axil_awvalid_o(awvalid), .axil_awready_i(awready),
    .axil_wdata_o(wdata_ax), .axil_wstrb_o(wstrb_ax), .axil_wvalid_o(wvalid), .axil_wready_i(wready),
    .axil_bresp_i(bresp), .axil_bvalid_i(bvalid), .axil_bready_o(bready),
    .axil_araddr_o(araddr), .axil_arprot_o(arprot), .axil_arvalid_o(arvalid), .axil_arready_i(arready),
    .axil_rdata_i(rdata), .axil_rresp_i(rresp), .axil_rvalid_i(rvalid), .axil_rready_o(rready)
`ifdef IOB2AXIL_RESP_ERR_EN
    , .err_o(err), .err_clr_i(err_clr)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave model: readies/responses driven at negedge after a per-channel delay, handshakes checked against the scoreboard
  always @(negedge clk) begin
    if (awvalid) begin awready = aw_cnt >= aw_dly; aw_cnt++; end else begin awready = 0; aw_cnt = 0; end
    if (wvalid) begin wready = w_cnt >= w_dly; w_cnt++; end else begin wready = 0; w_cnt = 0; end
    if (arvalid) begin arready = ar_cnt >= ar_dly; ar_cnt++; end else begin arready = 0; ar_cnt = 0; end
    if (bready) begin bvalid = b_cnt >= b_dly; b_cnt++; end else begin bvalid = 0; b_cnt = 0; end
    if (rready) begin rvalid = r_cnt >= r_dly; r_cnt++; end else begin rvalid = 0; r_cnt = 0; end
    rdata = rvalid ? r_val : 32'h0;
    bresp = resp_val;
    rresp = resp_val;
    if (arst_n) begin
      if (awvalid) aw_cycles++;
      if (wvalid) w_cycles++;
      chk("prot", {awprot, arprot}, 0);
      if (awvalid && awready) begin
        chk("aw_expected", wq.size() > 0, 1);
        if (wq.size() > 0) chk("awaddr", awaddr, wq[0].a);
      end
      if (wvalid && wready) begin
        chk("w_expected", wq.size() > 0, 1);
        if (wq.size() > 0) begin
          chk("wdata", wdata_ax, wq[0].d);
          chk("wstrb", wstrb_ax, wq[0].s);
        end
      end
      if (bready) chk("bready_after_hs", awvalid | wvalid, 0);
      if (bready && bvalid && wq.size() > 0) void'(wq.pop_front());
      if (arvalid && arready) begin
        chk("ar_expected", aq.size() > 0, 1);
        if (aq.size() > 0) chk("araddr", araddr, aq.pop_front());
      end
      if (rvalid_o) begin
        chk("rd_pending", rq.size() > 0, 1);
        if (rq.size() > 0) chk("iob_rdata", rdata_o, rq.pop_front());
      end
      if (rv_prev) chk("rvalid_pulse", rvalid_o, 0);
      if (arvalid | rready) chk("no_overlap_rd", awvalid | wvalid | bready, 0);
    end
    rv_prev = rvalid_o;
  end

  task automatic req(input logic we, input logic [20:0] a, input logic [31:0] d, input logic [3:0] s, input logic [31:0] rd);
    avalid = 1; addr = a; wdata = d; wstrb = we ? s : 4'h0;
    for (int i = 0; i < 200 && !ready_o; i++) @(negedge clk);
    chk("req_accept", ready_o, 1);
    if (we) wq.push_back({a, d, s});
    else begin aq.push_back(a); rq.push_back(rd); end
    @(negedge clk);
    avalid = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && !ready_o; i++) @(negedge clk);
    chk("idle_timeout", ready_o, 1);
  endtask

  initial begin
    tbl[0] = '{1'b1, 21'h100, 32'h11111111, 4'hF, 0, 0, 0, 0, 0, 32'h0};
    tbl[1] = '{1'b0, 21'h100, 32'h0, 4'h0, 0, 0, 1, 1, 0, 32'hA5A5_5A5A};
    tbl[2] = '{1'b1, 21'h1FFFFC, 32'hFFFF0000, 4'hC, 0, 2, 0, 0, 2, 32'h0};
    tbl[3] = '{1'b1, 21'h008, 32'h01234567, 4'h1, 2, 2, 0, 0, 1, 32'h0};
    tbl[4] = '{1'b0, 21'h1FFFFC, 32'h0, 4'h0, 3, 0, 4, 0, 0, 32'hFFFF_FFFF};
    tbl[5] = '{1'b0, 21'h000, 32'hFFFFFFFF, 4'h0, 0, 0, 0, 5, 0, 32'h0000_0001};
    repeat (2) @(negedge clk);
    chk("rst_ready", ready_o, 0);
    chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready, rvalid_o}, 0);
    chk("rst_payload", {awaddr, wdata_ax, wstrb_ax, rdata_o}, 0);
`ifdef IOB2AXIL_RESP_ERR_EN
    chk("rst_err", err, 0);
`endif
    arst_n = 1;
    #1 chk("ready_before_edge", ready_o, 0);
    @(negedge clk);
    chk("ready_after_rst", ready_o, 1);
    // zero-wait write timing
    req(1, 21'h10, 32'hDEADBEEF, 4'hF, 0);
    chk("w_c1_valids", {awvalid, wvalid, ready_o}, 3'b110);
    chk("w_c1_awaddr", awaddr, 21'h10);
    chk("w_c1_wdata", wdata_ax, 32'hDEADBEEF);
    chk("w_c1_wstrb", wstrb_ax, 4'hF);
    @(negedge clk);
    chk("w_c2", {awvalid, wvalid, bready, ready_o}, 4'b0010);
    @(negedge clk);
    chk("w_c3", {bready, ready_o}, 2'b01);
    // zero-wait read timing
    r_val = 32'hCAFE0001;
    req(0, 21'h30, 0, 0, 32'hCAFE0001);
    chk("r_c1", {arvalid, rready, ready_o}, 3'b100);
    chk("r_c1_araddr", araddr, 21'h30);
    @(negedge clk);
    chk("r_c2", {arvalid, rready, ready_o}, 3'b010);
    @(negedge clk);
    chk("r_c3", {rvalid_o, rready, ready_o}, 3'b101);
    chk("r_c3_rdata", rdata_o, 32'hCAFE0001);
    // read with rvalid delayed by 2
    r_dly = 2; r_val = 32'h12345678;
    req(0, 21'h24, 0, 0, 32'h12345678);
    wait_idle();
    chk("dly_rd_data", rdata_o, 32'h12345678);
    r_val = 32'h0;
    repeat (3) begin
      @(negedge clk);
      chk("rdata_stable", {rvalid_o, rdata_o}, {1'b0, 32'h12345678});
    end
    // write with awready delayed by 3
    r_dly = 0; aw_dly = 3; b_dly = 1; aw_cycles = 0; w_cycles = 0;
    req(1, 21'h40, 32'h0BADF00D, 4'h3, 0);
    wait_idle();
    chk("aw_held_cycles", aw_cycles, 4);
    chk("w_cycles", w_cycles, 1);
    // table-driven transfers
    for (int i = 0; i < 6; i++) begin
      aw_dly = tbl[i].aw; w_dly = tbl[i].w; ar_dly = tbl[i].ar; r_dly = tbl[i].r; b_dly = tbl[i].b;
      r_val = tbl[i].rd;
      req(tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].rd);
      wait_idle();
      if (!tbl[i].we) chk("tbl_rdata", rdata_o, tbl[i].rd);
    end
    // back-to-back write then read with avalid held
    aw_dly = 0; w_dly = 0; ar_dly = 0; r_dly = 0; b_dly = 0; r_val = 32'h5555AAAA;
    req(1, 21'h80, 32'h87654321, 4'hF, 0);
    req(0, 21'h84, 0, 0, 32'h5555AAAA);
    wait_idle();
    chk("b2b_rdata", rdata_o, 32'h5555AAAA);
`ifdef IOB2AXIL_RESP_ERR_EN
    resp_val = 2'b10;
    req(1, 21'h90, 32'h1, 4'h1, 0);
    wait_idle();
    @(negedge clk);
    chk("err_set", err, 1);
    resp_val = 2'b00;
    req(1, 21'h94, 32'h2, 4'h1, 0);
    wait_idle();
    chk("err_sticky", err, 1);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    chk("err_clr", err, 0);
`endif
    // reset while in RD_DATA
    r_dly = 50; r_val = 32'h77777777;
    req(0, 21'h50, 0, 0, 32'h77777777);
    for (int i = 0; i < 20 && !rready; i++) @(negedge clk);
    chk("reached_rd_data", rready, 1);
    #2 arst_n = 0;
    #1 chk("mid_rst_valids", {awvalid, wvalid, bready, arvalid, rready, rvalid_o, ready_o}, 0);
    chk("mid_rst_rdata", rdata_o, 0);
    rq.delete(); aq.delete();
    @(negedge clk);
    arst_n = 1;
    r_dly = 0; r_val = 32'h0F0F0F0F;
    @(negedge clk);
    chk("post_rst_ready", ready_o, 1);
    req(0, 21'h58, 0, 0, 32'h0F0F0F0F);
    wait_idle();
    chk("post_rst_rdata", rdata_o, 32'h0F0F0F0F);
    repeat (2) @(negedge clk);
    chk("wq_empty", wq.size(), 0);
    chk("aq_empty", aq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
